// File: rtl/md_sum_framer.sv
// Accumulates FRAME_LEN 2-bit samples (or a flushed partial frame) into a
// 4-bit sum and count, then holds the frame until the consumer takes it.
module md_sum_framer #(
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] IN_E,
  input  logic       IN_VALID,
  output logic       OUT_READY,
  input  logic       IN_FLUSH,
  output logic [3:0] OUT_SUM,
  output logic [2:0] OUT_CNT,
  output logic       OUT_VALID,
  input  logic       IN_READY
);

  localparam int unsigned SUM_W = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;

  // Ready is a pure state decode so no input can reach it combinationally.
  assign OUT_READY = (state_q != HOLD);
  assign accept    = IN_VALID && OUT_READY;
  assign sum_inc   = sum_q + SUM_W'(IN_E);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  assign OUT_SUM   = out_sum_q;
  assign OUT_CNT   = out_cnt_q;
  assign OUT_VALID = out_valid_q;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sum_d = SUM_W'(IN_E);
          cnt_d = CNT_W'(1);
          if (FRAME_LEN == 1) begin
            state_d     = HOLD;
            out_sum_d   = SUM_W'(IN_E);
            out_cnt_d   = CNT_W'(1);
            out_valid_d = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          sum_d = sum_inc;
          cnt_d = cnt_inc;
        end
        // A flush coincident with an accept closes the frame including that sample.
        if ((accept && (cnt_inc == CNT_W'(FRAME_LEN))) || IN_FLUSH) begin
          state_d     = HOLD;
          out_sum_d   = accept ? sum_inc : sum_q;
          out_cnt_d   = accept ? cnt_inc : cnt_q;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (IN_READY) begin
          state_d     = IDLE;
          sum_d       = '0;
          cnt_d       = '0;
          out_sum_d   = '0;
          out_cnt_d   = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
